// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types and default widths for the register-file arbiter
package rf_arb_pkg;
    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;
    typedef enum logic [1:0] {OWN_SPI_WR, OWN_SPI_RD, OWN_CORE} owner_t;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: multi-flop synchronizer chain with a configurable reset value
module bit_sync #(
    parameter int W = 1,
    parameter int STAGES = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [STAGES-1:0][W-1:0] chain;
    // shift the foreign-domain input through the flop chain
    always_ff @(posedge clk) begin
        if (rst) chain <= {STAGES{RST_VAL}};
        else chain <= {chain[STAGES-2:0], d};
    end
    assign q = chain[STAGES-1];
endmodule

// File: rtl/rf_arbiter.sv
// rf_arbiter: shares one register-file port between the SPI slave and the core
module rf_arbiter import rf_arb_pkg::*; #(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spi_csn,
    input  logic          spi_wre,
    input  logic [AW-1:0] spi_addr,
    input  logic [DW-1:0] spi_din,
    output logic [DW-1:0] spi_dout,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic [DW-1:0] core_rdata,
    output logic          core_rvalid,
    output logic          rf_en,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata
);
    logic          s_csn, s_wre, s_wre_d;
    logic [AW-1:0] s_addr, s_addr_d, wr_addr, rd_addr, pf_addr, cur_addr;
    logic [DW-1:0] s_din, wr_data, cur_wdata, core_rdata_q;
    logic          wr_pend, rd_pend, pf_valid, cur_we;
    logic          wr_edge, rd_trig, grant;
    state_t        state, state_nx;
    owner_t        owner, grant_own;

    bit_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn (
        .clk(clk), .rst(rst), .d(spi_csn), .q(s_csn)
    );
    bit_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_wre (
        .clk(clk), .rst(rst), .d(spi_wre), .q(s_wre)
    );
    bit_sync #(.W(AW + DW), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_bus (
        .clk(clk), .rst(rst), .d({spi_addr, spi_din}), .q({s_addr, s_din})
    );

    assign wr_edge = s_wre && !s_wre_d && !s_csn;
    // the address must hold for two cycles, and a pending read of it is not re-requested
    assign rd_trig = !s_csn && s_addr == s_addr_d && (!pf_valid || s_addr != pf_addr)
                     && !(rd_pend && rd_addr == s_addr);
    assign grant = wr_pend || rd_pend || core_req;
    assign grant_own = wr_pend ? OWN_SPI_WR : rd_pend ? OWN_SPI_RD : OWN_CORE;
    assign rf_we = rf_en && cur_we;
    assign rf_addr = cur_addr;
    assign rf_wdata = cur_wdata;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    // next state and access-phase outputs; core read data passes straight through in CAPTURE
    always_comb begin
        state_nx = state;
        rf_en = 1'b0;
        core_gnt = 1'b0;
        core_rvalid = 1'b0;
        core_rdata = core_rdata_q;
        case (state)
            IDLE: state_nx = grant ? ACCESS : IDLE;
            ACCESS: begin
                rf_en = 1'b1;
                core_gnt = owner == OWN_CORE;
                state_nx = cur_we ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                core_rvalid = owner == OWN_CORE;
                core_rdata = core_rvalid ? rf_rdata : core_rdata_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // grant latching, SPI pending flags, prefetch tracking and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= OWN_SPI_WR;
            cur_we <= 1'b0;
            cur_addr <= '0;
            cur_wdata <= '0;
            s_wre_d <= 1'b0;
            s_addr_d <= '0;
            wr_pend <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            rd_pend <= 1'b0;
            rd_addr <= '0;
            pf_addr <= '0;
            pf_valid <= 1'b0;
            spi_dout <= '0;
            core_rdata_q <= '0;
        end else begin
            s_wre_d <= s_wre;
            s_addr_d <= s_addr;
            if (state == IDLE && grant) begin
                owner <= grant_own;
                cur_we <= grant_own == OWN_SPI_WR || (grant_own == OWN_CORE && core_we);
                cur_addr <= wr_pend ? wr_addr : rd_pend ? rd_addr : core_addr;
                cur_wdata <= wr_pend ? wr_data : core_wdata;
            end
            if (state == ACCESS && cur_we) begin
                if (owner == OWN_SPI_WR) wr_pend <= 1'b0;
                if (cur_addr == pf_addr) pf_valid <= 1'b0;
            end
            if (state == CAPTURE) begin
                if (owner == OWN_SPI_RD) begin
                    spi_dout <= rf_rdata;
                    pf_addr <= cur_addr;
                    pf_valid <= 1'b1;
                    rd_pend <= 1'b0;
                end else begin
                    core_rdata_q <= rf_rdata;
                end
            end
            if (wr_edge) begin
                wr_pend <= 1'b1;
                wr_addr <= s_addr;
                wr_data <= s_din;
            end
            if (rd_trig) begin
                rd_pend <= 1'b1;
                rd_addr <= s_addr;
            end
            if (s_csn) begin
                wr_pend <= 1'b0;
                rd_pend <= 1'b0;
                pf_valid <= 1'b0;
            end
        end
    end

    // a second SPI write arriving before the first is issued would overwrite it
    wr_overrun: assert property (@(posedge clk) disable iff (rst)
        !(wr_edge && wr_pend && !(state == ACCESS && owner == OWN_SPI_WR)));
endmodule

// File: tb/tb_rf_arbiter.sv
// tb_rf_arbiter: scoreboard bench for the register-file arbiter
module tb_rf_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int SYNC = 2;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          spi_csn = 1'b1, spi_wre = 1'b0;
    logic [AW-1:0] spi_addr = '0;
    logic [DW-1:0] spi_din = '0;
    logic [DW-1:0] spi_dout;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_gnt, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          rf_en, rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata, rf_rdata;

    logic [DW-1:0] mem [256];
    acc_t exp_q[$];
    acc_t mon_e;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_arbiter #(.AW(AW), .DW(DW), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst),
        .spi_csn(spi_csn), .spi_wre(spi_wre), .spi_addr(spi_addr), .spi_din(spi_din),
        .spi_dout(spi_dout),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rdata(core_rdata),
        .core_rvalid(core_rvalid),
        .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata)
    );

    // register-file macro: 1-cycle read latency, preloaded during reset
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[8'h05] <= 8'h7E;
            mem[8'h07] <= 8'h5A;
            rf_rdata <= '0;
        end else begin
            if (rf_en && rf_we) mem[rf_addr] <= rf_wdata;
            if (rf_en && !rf_we) rf_rdata <= mem[rf_addr];
        end
    end

    // every register-file access must match the next expected one, in order
    always @(negedge clk) begin
        if (rf_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rf_unexpected: got we=%0b addr=%h data=%h, expected no access", rf_we, rf_addr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_we !== mon_e.we || rf_addr !== mon_e.addr || (mon_e.we && rf_wdata !== mon_e.data)) begin
                    errors++;
                    $display("FAIL rf_access: got we=%0b addr=%h data=%h, expected we=%0b addr=%h data=%h",
                             rf_we, rf_addr, rf_wdata, mon_e.we, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic wait_dout(input logic [DW-1:0] v, input string name);
        int n = 0;
        while (n < 30 && spi_dout !== v) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checks++;
        if (spi_dout !== v) begin
            errors++;
            $display("FAIL %s: spi_dout got %h expected %h", name, spi_dout, v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rf_en, rf_we, rf_addr, rf_wdata, core_gnt, core_rvalid, core_rdata, spi_dout} !== '0) begin
            errors++;
            $display("FAIL rst_outputs: got en=%0b we=%0b addr=%h wdata=%h gnt=%0b rv=%0b rdata=%h dout=%h expected all 0",
                     rf_en, rf_we, rf_addr, rf_wdata, core_gnt, core_rvalid, core_rdata, spi_dout);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({rf_en, core_gnt, core_rvalid, spi_dout} !== '0) begin
            errors++;
            $display("FAIL idle_outputs: got en=%0b gnt=%0b rv=%0b dout=%h expected 0", rf_en, core_gnt, core_rvalid, spi_dout);
        end
    endtask

    task automatic test_core_wr_rd();
        int n = 0;
        int gn = 0;
        logic got = 1'b0;
        logic rv = 1'b0;
        logic [DW-1:0] rd = '0;
        exp_q.push_back('{we: 1'b1, addr: 8'h10, data: 8'hA5});
        @(posedge clk);
        #1 core_req = 1'b1; core_we = 1'b1; core_addr = 8'h10; core_wdata = 8'hA5;
        while (n < 10 && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = core_gnt;
        end
        core_req = 1'b0;
        checks++;
        if (!got || n != 1) begin
            errors++;
            $display("FAIL core_wr_gnt: got gnt=%0b after %0d cycles, expected gnt after 1", got, n);
        end
        exp_q.push_back('{we: 1'b0, addr: 8'h10, data: 8'h00});
        @(posedge clk);
        #1 core_req = 1'b1; core_we = 1'b0;
        n = 0;
        while (n < 10 && !rv) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (core_gnt) begin gn = n; core_req = 1'b0; end
            if (core_rvalid) begin rv = 1'b1; rd = core_rdata; end
        end
        core_req = 1'b0;
        checks++;
        if (gn != 1) begin
            errors++;
            $display("FAIL core_rd_gnt: got gnt at cycle %0d expected 1", gn);
        end
        checks++;
        if (!rv || n != 2) begin
            errors++;
            $display("FAIL core_rd_latency: got rvalid=%0b at cycle %0d expected rvalid at 2", rv, n);
        end
        checks++;
        if (rd !== 8'hA5) begin
            errors++;
            $display("FAIL core_rdata: got %h expected a5", rd);
        end
    endtask

    task automatic test_collision();
        int n = 0;
        int wr_c = 0;
        int gc = 0;
        logic rv = 1'b0;
        logic [DW-1:0] rd = '0;
        spi_addr = 8'h20;
        spi_din = 8'h3C;
        exp_q.push_back('{we: 1'b0, addr: 8'h20, data: 8'h00});
        @(posedge clk);
        #1 spi_csn = 1'b0;
        repeat (15) @(posedge clk);
        #1 spi_wre = 1'b1;
        exp_q.push_back('{we: 1'b1, addr: 8'h20, data: 8'h3C});
        exp_q.push_back('{we: 1'b0, addr: 8'h20, data: 8'h00});
        exp_q.push_back('{we: 1'b0, addr: 8'h20, data: 8'h00});
        repeat (SYNC + 1) @(posedge clk);
        #1 core_req = 1'b1; core_we = 1'b0; core_addr = 8'h20;
        while (n < 20 && !rv) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (rf_en && rf_we && wr_c == 0) wr_c = n;
            if (core_gnt) begin gc = n; core_req = 1'b0; end
            if (core_rvalid) begin rv = 1'b1; rd = core_rdata; end
        end
        core_req = 1'b0;
        spi_wre = 1'b0;
        checks++;
        if (wr_c == 0 || wr_c + SYNC + 1 > SYNC + 3) begin
            errors++;
            $display("FAIL spi_wr_latency: got write %0d cycles after spi_wre, expected within %0d", wr_c + SYNC + 1, SYNC + 3);
        end
        checks++;
        if (wr_c == 0 || gc - wr_c != 2) begin
            errors++;
            $display("FAIL collision_order: got spi write at %0d core_gnt at %0d, expected gnt 2 cycles after write", wr_c, gc);
        end
        checks++;
        if (!rv || rd !== 8'h3C) begin
            errors++;
            $display("FAIL collision_rdata: got rvalid=%0b rdata=%h expected 3c", rv, rd);
        end
        wait_dout(8'h3C, "collision_refetch");
    endtask

    task automatic test_prefetch();
        int n = 0;
        int cnt = 0;
        @(posedge clk);
        #1 spi_addr = 8'h00;
        exp_q.push_back('{we: 1'b0, addr: 8'h00, data: 8'h00});
        repeat (15) @(posedge clk);
        #1 spi_addr = 8'h05;
        exp_q.push_back('{we: 1'b0, addr: 8'h05, data: 8'h00});
        while (n < SYNC + 10 && spi_dout !== 8'h7E) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checks++;
        if (spi_dout !== 8'h7E || n > SYNC + 5) begin
            errors++;
            $display("FAIL prefetch: got spi_dout=%h after %0d cycles, expected 7e within %0d", spi_dout, n, SYNC + 5);
        end
        repeat (20) begin
            @(negedge clk);
            if (rf_en) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL prefetch_no_reread: got %0d accesses expected 0", cnt);
        end
    endtask

    task automatic test_invalidate();
        int n = 0;
        logic got = 1'b0;
        exp_q.push_back('{we: 1'b1, addr: 8'h05, data: 8'h99});
        exp_q.push_back('{we: 1'b0, addr: 8'h05, data: 8'h00});
        @(posedge clk);
        #1 core_req = 1'b1; core_we = 1'b1; core_addr = 8'h05; core_wdata = 8'h99;
        while (n < 10 && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = core_gnt;
        end
        core_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL inval_gnt: got no gnt in %0d cycles expected gnt", n);
        end
        wait_dout(8'h99, "inval_refetch");
    endtask

    task automatic test_csn_deassert();
        int cnt = 0;
        logic rv = 1'b0;
        logic [DW-1:0] rd = '0;
        exp_q.push_back('{we: 1'b0, addr: 8'h10, data: 8'h00});
        @(posedge clk);
        #1 spi_addr = 8'h07;
        repeat (SYNC + 1) @(posedge clk);
        #1 core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10; spi_csn = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (core_gnt) core_req = 1'b0;
            if (rf_en) cnt++;
            if (core_rvalid) begin rv = 1'b1; rd = core_rdata; end
        end
        core_req = 1'b0;
        checks++;
        if (cnt != 1) begin
            errors++;
            $display("FAIL csn_drop_prefetch: got %0d accesses expected 1", cnt);
        end
        checks++;
        if (!rv || rd !== 8'hA5) begin
            errors++;
            $display("FAIL csn_core_read: got rvalid=%0b rdata=%h expected a5", rv, rd);
        end
        exp_q.push_back('{we: 1'b0, addr: 8'h07, data: 8'h00});
        @(posedge clk);
        #1 spi_csn = 1'b0;
        wait_dout(8'h5A, "csn_refetch");
    endtask

    task automatic test_reset_mid_access();
        int n = 0;
        logic got = 1'b0;
        @(posedge clk);
        #1 spi_csn = 1'b1;
        repeat (6) @(posedge clk);
        exp_q.push_back('{we: 1'b0, addr: 8'h10, data: 8'h00});
        #1 core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
        while (n < 10 && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = core_gnt;
        end
        rst = 1'b1;
        core_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (!got || {rf_en, rf_we, rf_addr, rf_wdata, core_gnt, core_rvalid, core_rdata, spi_dout} !== '0) begin
            errors++;
            $display("FAIL rst_mid_access: got gnt_seen=%0b en=%0b we=%0b addr=%h wdata=%h gnt=%0b rv=%0b rdata=%h dout=%h expected all 0",
                     got, rf_en, rf_we, rf_addr, rf_wdata, core_gnt, core_rvalid, core_rdata, spi_dout);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: got %0d outstanding accesses expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_core_wr_rd();
        test_collision();
        test_prefetch();
        test_invalidate();
        test_csn_deassert();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
